async_trig_addr_capture: RTL and testbench

Upstream stage of the ASYNC readout path. Generates the circular-buffer write address and watches the synchronous trigger input. On each accepted trigger it pushes the current write address into an internal FWFT trigger-address FIFO, with pre-fill guard, holdoff and overflow accounting. The circular-buffer-to-DDR3 mover drains that FIFO through `circ_buf_trig_addr` / `trig_fifo_empty` / `trig_addr_rd_en`.

---
 rtl/async_trig_pkg.sv | 8 +
 rtl/trig_addr_fifo_fwft.sv | 47 ++++
 rtl/async_trig_addr_capture.sv | 134 +++++++++++++
 tb/tb_async_trig_addr_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_trig_pkg.sv
// async_trig_pkg: shared state type and sizing constants for the trigger-address capture path
package async_trig_pkg;
    typedef enum logic [1:0] {IDLE, PREFILL, ARMED, HOLDOFF} trig_state_t;
    localparam int ADDR_W          = 16;
    localparam int TRIG_FIFO_DEPTH = 16;
    localparam int STATS_ACC_W     = 24;
    localparam int STATS_DROP_W    = 16;
endpackage

// File: rtl/trig_addr_fifo_fwft.sv
// trig_addr_fifo_fwft: first-word-fall-through register FIFO with synchronous flush
module trig_addr_fifo_fwft import async_trig_pkg::*; #(
    parameter int DEPTH = TRIG_FIFO_DEPTH,
    parameter int WIDTH = ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head reads as zero while empty so the output is defined out of reset
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; entries need no reset because head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/async_trig_addr_capture.sv
// async_trig_addr_capture: circular-buffer write address and trigger-address capture; ASYNC_TRIG_STATS_EN enables stats counters
module async_trig_addr_capture #(
    parameter int TRIG_FIFO_DEPTH = async_trig_pkg::TRIG_FIFO_DEPTH,
    parameter int ADDR_W          = async_trig_pkg::ADDR_W
) (
    input  logic              adc_clk,
    input  logic              reset_clk_adc_n,
    input  logic              cbuf_wr_en,
    input  logic              cbuf_trig_en,
    input  logic              trig_in,
    input  logic [11:0]       async_pre_trig,
    input  logic [15:0]       holdoff_len,
    input  logic              fifo_flush,
    input  logic              trig_addr_rd_en,
    output logic [ADDR_W-1:0] circ_buf_wr_addr,
    output logic [ADDR_W-1:0] circ_buf_trig_addr,
    output logic              trig_fifo_empty,
    output logic              trig_fifo_full,
    output logic              trig_armed,
    output logic [23:0]       accepted_trig_cnt,
    output logic [15:0]       dropped_trig_cnt,
    input  logic              stats_clr
);
    import async_trig_pkg::*;

    trig_state_t       state, state_nx;
    logic              run, trig_in_q, trig_edge, capture;
    logic              pend, room, push, fifo_full;
    logic [ADDR_W-1:0] pend_addr;
    logic [11:0]       prefill_cnt;
    logic [15:0]       holdoff_cnt;

    assign run       = cbuf_wr_en & cbuf_trig_en;
    assign trig_edge = trig_in & ~trig_in_q;
    assign capture   = (state == ARMED) & trig_edge;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts then
    assign room      = ~fifo_full | trig_addr_rd_en;
    assign push      = pend & room;
    assign trig_fifo_full = fifo_full;

    // Write address counter and trigger level history
    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) begin
            circ_buf_wr_addr <= '0;
            trig_in_q        <= 1'b0;
        end else begin
            trig_in_q <= trig_in;
            if (cbuf_wr_en) circ_buf_wr_addr <= circ_buf_wr_addr + ADDR_W'(1);
        end
    end

    // State register
    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) state <= IDLE;
        else                  state <= state_nx;
    end

    // Next-state logic; losing either enable returns to IDLE from anywhere
    always_comb begin
        state_nx = state;
        if (!run) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = PREFILL;
                PREFILL: state_nx = (prefill_cnt >= async_pre_trig) ? ARMED : PREFILL;
                ARMED:   state_nx = (trig_edge && holdoff_len != 16'd0) ? HOLDOFF : ARMED;
                HOLDOFF: state_nx = (holdoff_cnt == 16'd1) ? ARMED : HOLDOFF;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        trig_armed = state == ARMED;
    end

    // Pre-fill (saturating) and holdoff timers
    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) begin
            prefill_cnt <= '0;
            holdoff_cnt <= '0;
        end else begin
            if (state == IDLE) prefill_cnt <= '0;
            else if (state == PREFILL && prefill_cnt != '1) prefill_cnt <= prefill_cnt + 12'd1;
            if (capture) holdoff_cnt <= holdoff_len;
            else if (state == HOLDOFF) holdoff_cnt <= holdoff_cnt - 16'd1;
        end
    end

    // Captured address is staged one cycle before it enters the FIFO
    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend <= capture;
            if (capture) pend_addr <= circ_buf_wr_addr;
        end
    end

    trig_addr_fifo_fwft #(.DEPTH(TRIG_FIFO_DEPTH), .WIDTH(ADDR_W)) u_fifo (
        .clk   (adc_clk),
        .rst_n (reset_clk_adc_n),
        .flush (fifo_flush),
        .push  (push),
        .din   (pend_addr),
        .pop   (trig_addr_rd_en),
        .head  (circ_buf_trig_addr),
        .empty (trig_fifo_empty),
        .full  (fifo_full)
    );

`ifdef ASYNC_TRIG_STATS_EN
    // Accepted count wraps, dropped count saturates; clear wins over increments
    always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
        if (!reset_clk_adc_n) begin
            accepted_trig_cnt <= '0;
            dropped_trig_cnt  <= '0;
        end else if (stats_clr) begin
            accepted_trig_cnt <= '0;
            dropped_trig_cnt  <= '0;
        end else begin
            if (push) accepted_trig_cnt <= accepted_trig_cnt + 24'd1;
            if (pend && !room && dropped_trig_cnt != '1) dropped_trig_cnt <= dropped_trig_cnt + 16'd1;
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr  = stats_clr;
    assign accepted_trig_cnt = '0;
    assign dropped_trig_cnt  = '0;
`endif
endmodule

// File: tb/tb_async_trig_addr_capture.sv
// tb_async_trig_addr_capture: vector table, directed corner sequences and random run against a cycle-arithmetic model
module tb_async_trig_addr_capture;
    localparam int DEPTH = 16;
`ifdef ASYNC_TRIG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        adc_clk, reset_clk_adc_n;
    logic        cbuf_wr_en, cbuf_trig_en, trig_in, fifo_flush, trig_addr_rd_en, stats_clr;
    logic [11:0] async_pre_trig;
    logic [15:0] holdoff_len;
    logic [15:0] circ_buf_wr_addr, circ_buf_trig_addr;
    logic        trig_fifo_empty, trig_fifo_full, trig_armed;
    logic [23:0] accepted_trig_cnt;
    logic [15:0] dropped_trig_cnt;

    async_trig_addr_capture #(.TRIG_FIFO_DEPTH(DEPTH), .ADDR_W(16)) dut (
        .adc_clk(adc_clk), .reset_clk_adc_n(reset_clk_adc_n),
        .cbuf_wr_en(cbuf_wr_en), .cbuf_trig_en(cbuf_trig_en), .trig_in(trig_in),
        .async_pre_trig(async_pre_trig), .holdoff_len(holdoff_len), .fifo_flush(fifo_flush),
        .trig_addr_rd_en(trig_addr_rd_en), .circ_buf_wr_addr(circ_buf_wr_addr),
        .circ_buf_trig_addr(circ_buf_trig_addr), .trig_fifo_empty(trig_fifo_empty),
        .trig_fifo_full(trig_fifo_full), .trig_armed(trig_armed),
        .accepted_trig_cnt(accepted_trig_cnt), .dropped_trig_cnt(dropped_trig_cnt),
        .stats_clr(stats_clr)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    int total = 0;
    int passed = 0;

    // Reference model: edges are numbered from reset; arming is derived from
    // the edge where both enables came up (e0), the pre-trigger length and the
    // edge before which holdoff expires.
    int unsigned addr_m, pend_addr_m, acc_m, drop_m;
    int unsigned q[$];
    bit          ti_q_m, pend_m, run_prev_m, armed_m;
    longint      k, e0, hold_until;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, k);
    endtask

    task automatic model_reset();
        addr_m = 0; pend_addr_m = 0; acc_m = 0; drop_m = 0; q.delete();
        ti_q_m = 0; pend_m = 0; run_prev_m = 0; armed_m = 0;
        k = 0; e0 = 0; hold_until = 0;
    endtask

    task automatic do_reset();
        reset_clk_adc_n = 1'b0;
        cbuf_wr_en = 0; cbuf_trig_en = 0; trig_in = 0; fifo_flush = 0;
        trig_addr_rd_en = 0; stats_clr = 0;
        repeat (2) @(posedge adc_clk);
        @(negedge adc_clk);
        reset_clk_adc_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input bit wr, input bit te, input bit ti, input bit rd, input bit fl, input bit clr);
        bit run, edg, acc_now, room;
        cbuf_wr_en = wr; cbuf_trig_en = te; trig_in = ti;
        trig_addr_rd_en = rd; fifo_flush = fl; stats_clr = clr;
        @(posedge adc_clk);
        run = wr & te;
        edg = ti & !ti_q_m;
        ti_q_m = ti;
        acc_now = armed_m & edg;
        room = (q.size() < DEPTH) || rd;
        if (fl) q.delete();
        else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (pend_m && room) q.push_back(pend_addr_m);
        end
        if (STATS && clr) begin
            acc_m = 0; drop_m = 0;
        end else if (STATS && pend_m) begin
            if (room) acc_m = (acc_m + 1) & 32'hFF_FFFF;
            else if (drop_m < 65535) drop_m++;
        end
        pend_m = acc_now;
        if (acc_now) pend_addr_m = addr_m;
        if (wr) addr_m = (addr_m + 1) & 32'hFFFF;
        if (acc_now) hold_until = k + holdoff_len + 1;
        if (run && !run_prev_m) e0 = k;
        if (!run) hold_until = 0;
        run_prev_m = run;
        armed_m = run && (k + 1 >= e0 + async_pre_trig + 2) && (k + 1 >= hold_until);
        k++;
        #1;
        chk("wr_addr", circ_buf_wr_addr, addr_m);
        chk("empty", trig_fifo_empty, q.size() == 0);
        chk("full", trig_fifo_full, q.size() == DEPTH);
        chk("head", circ_buf_trig_addr, q.size() > 0 ? q[0] : 0);
        chk("armed", trig_armed, armed_m);
        chk("acc_cnt", accepted_trig_cnt, acc_m);
        chk("drop_cnt", dropped_trig_cnt, drop_m);
    endtask

    typedef struct {
        int          n;
        bit          wr, te, ti, rd;
        logic [15:0] addr;
        bit          empty;
        logic [15:0] head;
        bit          armed;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1,  1, 1, 0, 0, 16'h0001, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{9,  1, 1, 0, 0, 16'h000A, 1'b1, 16'h0000, 1'b1};
        tbl[2]  = '{22, 1, 1, 0, 0, 16'h0020, 1'b1, 16'h0000, 1'b1};
        tbl[3]  = '{1,  1, 1, 1, 0, 16'h0021, 1'b1, 16'h0000, 1'b1};
        tbl[4]  = '{1,  1, 1, 0, 0, 16'h0022, 1'b0, 16'h0020, 1'b1};
        tbl[5]  = '{1,  1, 1, 0, 1, 16'h0023, 1'b1, 16'h0000, 1'b1};
        tbl[6]  = '{1,  1, 0, 0, 0, 16'h0024, 1'b1, 16'h0000, 1'b0};
        tbl[7]  = '{1,  1, 1, 0, 0, 16'h0025, 1'b1, 16'h0000, 1'b0};
        tbl[8]  = '{2,  1, 1, 0, 0, 16'h0027, 1'b1, 16'h0000, 1'b0};
        tbl[9]  = '{1,  1, 1, 1, 0, 16'h0028, 1'b1, 16'h0000, 1'b0};
        tbl[10] = '{6,  1, 1, 0, 0, 16'h002E, 1'b1, 16'h0000, 1'b1};
        tbl[11] = '{1,  1, 1, 1, 0, 16'h002F, 1'b1, 16'h0000, 1'b1};
        tbl[12] = '{1,  1, 1, 0, 0, 16'h0030, 1'b0, 16'h002E, 1'b1};

        async_pre_trig = 12'd8;
        holdoff_len = 16'd0;
        do_reset();
        #1;
        chk("rst wr_addr", circ_buf_wr_addr, 0);
        chk("rst empty", trig_fifo_empty, 1);
        chk("rst full", trig_fifo_full, 0);
        chk("rst head", circ_buf_trig_addr, 0);
        chk("rst armed", trig_armed, 0);
        chk("rst acc", accepted_trig_cnt, 0);
        chk("rst drop", dropped_trig_cnt, 0);

        // Basic capture and pre-fill guard
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) cycle(tbl[i].wr, tbl[i].te, tbl[i].ti, tbl[i].rd, 0, 0);
            chk($sformatf("tbl%0d addr", i), circ_buf_wr_addr, tbl[i].addr);
            chk($sformatf("tbl%0d empty", i), trig_fifo_empty, tbl[i].empty);
            chk($sformatf("tbl%0d head", i), circ_buf_trig_addr, tbl[i].head);
            chk($sformatf("tbl%0d armed", i), trig_armed, tbl[i].armed);
        end
        chk("basic acc", accepted_trig_cnt, STATS ? 2 : 0);

        // Holdoff: edges at 10, 60, 111 with holdoff 100
        async_pre_trig = 12'd0;
        holdoff_len = 16'd100;
        do_reset();
        for (int c = 0; c < 120; c++) cycle(1, 1, c == 10 || c == 60 || c == 111, 0, 0, 0);
        chk("hold head0", circ_buf_trig_addr, 16'd10);
        cycle(1, 1, 0, 1, 0, 0);
        chk("hold head1", circ_buf_trig_addr, 16'd111);
        cycle(1, 1, 0, 1, 0, 0);
        chk("hold empty", trig_fifo_empty, 1);

        // Address wrap with back-to-back accepted edges
        holdoff_len = 16'd0;
        do_reset();
        for (int c = 0; c < 65538; c++) cycle(1, 1, c == 65534 || c == 65536, 0, 0, 0);
        chk("wrap head0", circ_buf_trig_addr, 16'hFFFE);
        cycle(1, 1, 0, 1, 0, 0);
        chk("wrap head1", circ_buf_trig_addr, 16'h0000);
        chk("wrap nonempty", trig_fifo_empty, 0);
        cycle(1, 1, 0, 1, 0, 0);
        chk("wrap empty", trig_fifo_empty, 1);

        // Full FIFO: 18 triggers, then push+pop while full, then flush and stats clear
        do_reset();
        for (int c = 0; c < 38; c++) begin
            cycle(1, 1, c >= 2 && c <= 36 && c % 2 == 0, 0, 0, 0);
            if (c == 32) chk("full early", trig_fifo_full, 0);
            if (c == 33) chk("full at 16", trig_fifo_full, 1);
        end
        chk("full head", circ_buf_trig_addr, 16'd2);
        chk("full drop", dropped_trig_cnt, STATS ? 2 : 0);
        chk("full acc", accepted_trig_cnt, STATS ? 16 : 0);
        cycle(1, 1, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        chk("pushpop full", trig_fifo_full, 1);
        chk("pushpop head", circ_buf_trig_addr, 16'd4);
        chk("pushpop acc", accepted_trig_cnt, STATS ? 17 : 0);
        cycle(1, 1, 0, 0, 1, 1);
        chk("flush empty", trig_fifo_empty, 1);
        chk("clr acc", accepted_trig_cnt, 0);
        chk("clr drop", dropped_trig_cnt, 0);

        // Disable during holdoff keeps FIFO, re-enable restarts pre-fill
        holdoff_len = 16'd100;
        do_reset();
        for (int c = 0; c < 20; c++) cycle(1, 1, c == 5, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("dis armed", trig_armed, 0);
        chk("dis retained", circ_buf_trig_addr, 16'd5);
        holdoff_len = 16'd0;
        for (int c = 21; c < 25; c++) cycle(1, 1, c == 23, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        chk("reen head", circ_buf_trig_addr, 16'd23);
        cycle(1, 1, 1, 0, 0, 0);
        #2;
        reset_clk_adc_n = 1'b0;
        #1;
        chk("arst wr_addr", circ_buf_wr_addr, 0);
        chk("arst empty", trig_fifo_empty, 1);
        chk("arst full", trig_fifo_full, 0);
        chk("arst head", circ_buf_trig_addr, 0);
        chk("arst armed", trig_armed, 0);
        chk("arst acc", accepted_trig_cnt, 0);
        chk("arst drop", dropped_trig_cnt, 0);
        @(negedge adc_clk);
        reset_clk_adc_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0);
        chk("arst no push", trig_fifo_empty, 1);

        // Randomized run; settings only change while enables are down
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                cycle(1, 0, 0, 0, 0, 0);
                async_pre_trig = 12'($urandom_range(0, 6));
                holdoff_len = 16'($urandom_range(0, 8));
            end
            cycle($urandom_range(0, 31) != 0, $urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 255) == 0, $urandom_range(0, 255) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
